// File: rtl/prga_fifo_pkg.sv
// Shared definitions for the fifo_count family: read-mode encoding, a
// constant log2 helper and the parameter legality predicates used at
// elaboration time by every FIFO instance.
package prga_fifo_pkg;

    // Read-side behaviour of the FIFO.
    typedef enum logic {
        STD  = 1'b0,   // dout updates one cycle after an accepted rd
        FWFT = 1'b1    // head entry is presented on dout before rd
    } lookahead_mode_e;

    localparam int DEPTH_LOG2_MIN = 1;
    localparam int DEPTH_LOG2_MAX = 10;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic bit depth_log2_legal(input int depth_log2);
        return (depth_log2 >= DEPTH_LOG2_MIN) && (depth_log2 <= DEPTH_LOG2_MAX);
    endfunction

    function automatic bit lookahead_legal(input int lookahead);
        return (lookahead == int'(STD)) || (lookahead == int'(FWFT));
    endfunction

    // almost_full threshold may sit anywhere from 1 up to the full capacity.
    function automatic bit af_thresh_legal(input int depth_log2, input int af_thresh);
        return (af_thresh >= 1) && (af_thresh <= (1 << depth_log2));
    endfunction

    // almost_empty threshold may sit anywhere from 0 up to capacity-1.
    function automatic bit ae_thresh_legal(input int depth_log2, input int ae_thresh);
        return (ae_thresh >= 0) && (ae_thresh <= (1 << depth_log2) - 1);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage for fifo_count: one synchronous write port and
// one registered synchronous read port. Only the read data register is
// reset so that dout is never X after reset; the array itself is not.
module fifo_ram
    import prga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Store the write data at the addressed entry.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read: the addressed entry appears one edge after rd_en_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_count.sv
// Single-clock FIFO with occupancy counter, programmable almost flags,
// sticky overflow/underflow and a synchronous flush.
//
// Handshake: a write is accepted on an edge where wr=1, full=0 and
// flush=0; a read/pop is accepted on an edge where rd=1, empty=0 and
// flush=0. Requests outside those conditions are dropped (and, unless
// flush is high, raise the matching sticky error flag). full/empty are
// taken from registered state, so a pop in the same cycle never makes
// room for a write that arrived while full.
//
// In lookahead mode a valid bit marks that the RAM read register holds
// the head entry. The counter includes entries not yet fetched, so after
// a write into an empty FIFO count is 1 while empty stays high for the
// one prefetch cycle.
module fifo_count
    import prga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3,
    parameter int LOOKAHEAD  = 0,
    parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int              DEPTH      = 1 << DEPTH_LOG2;
    localparam int              ADDR_WIDTH = clog2(DEPTH);
    localparam int              CW         = DEPTH_LOG2 + 1;
    localparam bit              FWFT_MODE  = (LOOKAHEAD == int'(FWFT));
    localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0]   AF_C       = CW'(AF_THRESH);
    localparam logic [CW-1:0]   AE_C       = CW'(AE_THRESH);

    // Reject illegal parameterisations at elaboration.
    if (!depth_log2_legal(DEPTH_LOG2)) begin : g_bad_depth
        $error("fifo_count: DEPTH_LOG2 must be in 1..10");
    end
    if (!lookahead_legal(LOOKAHEAD)) begin : g_bad_lookahead
        $error("fifo_count: LOOKAHEAD must be 0 or 1");
    end
    if (!af_thresh_legal(DEPTH_LOG2, AF_THRESH)) begin : g_bad_af
        $error("fifo_count: AF_THRESH must be in 1..DEPTH");
    end
    if (!ae_thresh_legal(DEPTH_LOG2, AE_THRESH)) begin : g_bad_ae
        $error("fifo_count: AE_THRESH must be in 0..DEPTH-1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  full_w;
    logic                  empty_w;
    logic                  wr_accept;
    logic                  rd_accept;
    logic [CW-1:0]         unfetched;
    logic                  fetch;
    logic                  ram_rd_en;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // Decode flags from registered state and qualify the requests.
    always_comb begin
        full_w    = (count_q == DEPTH_C);
        empty_w   = FWFT_MODE ? ~valid_q : (count_q == '0);
        wr_accept = wr & ~full_w & ~flush;
        rd_accept = rd & ~empty_w & ~flush;
        // Entries in the RAM that have not been moved into the read register.
        unfetched = count_q - CW'(valid_q);
        // Refill the read register whenever it is free or being popped.
        fetch     = FWFT_MODE & ~flush & (unfetched != '0) & (~valid_q | rd_accept);
        ram_rd_en = FWFT_MODE ? fetch : rd_accept;
    end

    // Next-state for pointers, counter, prefetch valid bit and sticky errors.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        valid_d     = valid_q;
        overflow_d  = overflow_q | (wr & full_w & ~flush);
        underflow_d = underflow_q | (rd & empty_w & ~flush);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            valid_d  = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
            if (ram_rd_en) begin
                rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            end
            case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (!FWFT_MODE) begin
                valid_d = 1'b0;
            end else if (fetch) begin
                valid_d = 1'b1;
            end else if (rd_accept) begin
                valid_d = 1'b0;
            end
        end
    end

    // Control state registers; reset overrides flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk),
        .rst_i     (rst),
        .wr_en_i   (wr_accept),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (din),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign dout         = ram_rd_data;

endmodule

// File: tb/tb_fifo_count.sv
// Directed bench for fifo_count: a standard-read instance and a lookahead
// instance share one stimulus stream; each scenario task checks both.
module tb_fifo_count;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr;
    logic [31:0] din;
    logic        rd;

    logic        full_s, almost_full_s, empty_s, almost_empty_s, overflow_s, underflow_s;
    logic [31:0] dout_s;
    logic [3:0]  count_s;
    logic        full_l, almost_full_l, empty_l, almost_empty_l, overflow_l, underflow_l;
    logic [31:0] dout_l;
    logic [3:0]  count_l;

    int checks;
    int failures;

    logic [31:0] fill_data [8];

    fifo_count #(
        .DATA_WIDTH (32), .DEPTH_LOG2 (3), .LOOKAHEAD (0), .AF_THRESH (7), .AE_THRESH (1)
    ) dut_s (
        .clk (clk), .rst (rst), .flush (flush), .wr (wr), .din (din),
        .full (full_s), .almost_full (almost_full_s), .rd (rd), .dout (dout_s),
        .empty (empty_s), .almost_empty (almost_empty_s), .count (count_s),
        .overflow (overflow_s), .underflow (underflow_s)
    );

    fifo_count #(
        .DATA_WIDTH (32), .DEPTH_LOG2 (3), .LOOKAHEAD (1), .AF_THRESH (7), .AE_THRESH (1)
    ) dut_l (
        .clk (clk), .rst (rst), .flush (flush), .wr (wr), .din (din),
        .full (full_l), .almost_full (almost_full_l), .rd (rd), .dout (dout_l),
        .empty (empty_l), .almost_empty (almost_empty_l), .count (count_l),
        .overflow (overflow_l), .underflow (underflow_l)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: apply one cycle of inputs, sample 1ns after the edge.
    task automatic tick(input logic w, input logic [31:0] d, input logic r, input logic f);
        wr    = w;
        din   = d;
        rd    = r;
        flush = f;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] exp_status;
        // {count, empty, full, almost_empty, almost_full, overflow, underflow}
        exp_status = 10'b0000_1_0_1_0_0_0;
        // Dirty the FIFOs first so reset has something to clear.
        rst = 1'b0;
        tick(1'b1, 32'hABCD_0001, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        apply_reset();
        checks++; if ({count_s, empty_s, full_s, almost_empty_s, almost_full_s, overflow_s, underflow_s} !== exp_status) begin failures++; $display("FAIL reset_status_std got=%b exp=%b", {count_s, empty_s, full_s, almost_empty_s, almost_full_s, overflow_s, underflow_s}, exp_status); end
        checks++; if ({count_l, empty_l, full_l, almost_empty_l, almost_full_l, overflow_l, underflow_l} !== exp_status) begin failures++; $display("FAIL reset_status_la got=%b exp=%b", {count_l, empty_l, full_l, almost_empty_l, almost_full_l, overflow_l, underflow_l}, exp_status); end
        checks++; if (dout_s !== 32'h0) begin failures++; $display("FAIL reset_dout_std got=%h exp=%h", dout_s, 32'h0); end
        checks++; if (dout_l !== 32'h0) begin failures++; $display("FAIL reset_dout_la got=%h exp=%h", dout_l, 32'h0); end
    endtask

    task automatic test_fill_drain();
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, fill_data[i], 1'b0, 1'b0);
            checks++; if (count_s !== 4'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count_s, i + 1); end
            checks++; if (almost_full_s !== (i + 1 >= 7)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full_s, (i + 1 >= 7)); end
            checks++; if (full_s !== (i == 7)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full_s, (i == 7)); end
            checks++; if (almost_empty_s !== (i + 1 <= 1)) begin failures++; $display("FAIL fill_ae[%0d] got=%b exp=%b", i, almost_empty_s, (i + 1 <= 1)); end
        end
        checks++; if (full_l !== 1'b1 || count_l !== 4'd8) begin failures++; $display("FAIL fill_la full=%b count=%0d exp full=1 count=8", full_l, count_l); end
        checks++; if (empty_l !== 1'b0 || dout_l !== 32'h5A) begin failures++; $display("FAIL fill_la_head empty=%b dout=%h exp empty=0 dout=5a", empty_l, dout_l); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (dout_s !== fill_data[i]) begin failures++; $display("FAIL drain_dout_std[%0d] got=%h exp=%h", i, dout_s, fill_data[i]); end
            checks++; if (count_s !== 4'(7 - i)) begin failures++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count_s, 7 - i); end
            if (i < 7) begin
                checks++; if (dout_l !== fill_data[i + 1] || empty_l !== 1'b0) begin failures++; $display("FAIL drain_dout_la[%0d] got=%h empty=%b exp=%h empty=0", i, dout_l, empty_l, fill_data[i + 1]); end
            end
        end
        checks++; if (empty_s !== 1'b1 || count_s !== 4'd0) begin failures++; $display("FAIL drain_end_std empty=%b count=%0d exp empty=1 count=0", empty_s, count_s); end
        checks++; if (empty_l !== 1'b1 || count_l !== 4'd0) begin failures++; $display("FAIL drain_end_la empty=%b count=%0d exp empty=1 count=0", empty_l, count_l); end
        checks++; if (overflow_s !== 1'b0 || underflow_s !== 1'b0) begin failures++; $display("FAIL drain_err_std ovf=%b udf=%b exp 0 0", overflow_s, underflow_s); end
    endtask

    task automatic test_lookahead();
        apply_reset();
        tick(1'b1, fill_data[0], 1'b0, 1'b0);
        checks++; if (count_l !== 4'd1 || empty_l !== 1'b1) begin failures++; $display("FAIL la_prefetch count=%0d empty=%b exp count=1 empty=1", count_l, empty_l); end
        checks++; if (count_s !== 4'd1 || empty_s !== 1'b0) begin failures++; $display("FAIL std_first_write count=%0d empty=%b exp count=1 empty=0", count_s, empty_s); end
        tick(1'b1, fill_data[1], 1'b0, 1'b0);
        checks++; if (empty_l !== 1'b0 || dout_l !== 32'h5A) begin failures++; $display("FAIL la_first_word empty=%b dout=%h exp empty=0 dout=5a", empty_l, dout_l); end
        // rd held high while words keep streaming in: one pop per cycle.
        for (int k = 0; k < 8; k++) begin
            tick((k + 2 < 8), (k + 2 < 8) ? fill_data[(k + 2) % 8] : 32'h0, 1'b1, 1'b0);
            checks++; if (dout_s !== fill_data[k]) begin failures++; $display("FAIL stream_dout_std[%0d] got=%h exp=%h", k, dout_s, fill_data[k]); end
            if (k < 7) begin
                checks++; if (dout_l !== fill_data[k + 1] || empty_l !== 1'b0) begin failures++; $display("FAIL stream_dout_la[%0d] got=%h empty=%b exp=%h empty=0", k, dout_l, empty_l, fill_data[k + 1]); end
            end
        end
        checks++; if (empty_l !== 1'b1 || count_l !== 4'd0) begin failures++; $display("FAIL stream_end_la empty=%b count=%0d exp empty=1 count=0", empty_l, count_l); end
        checks++; if (underflow_l !== 1'b0 || underflow_s !== 1'b0) begin failures++; $display("FAIL stream_udf la=%b std=%b exp 0 0", underflow_l, underflow_s); end
    endtask

    task automatic test_overflow_underflow();
        apply_reset();
        for (int i = 0; i < 8; i++) tick(1'b1, fill_data[i], 1'b0, 1'b0);
        tick(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        checks++; if (count_s !== 4'd8 || overflow_s !== 1'b1) begin failures++; $display("FAIL ovf_std count=%0d ovf=%b exp count=8 ovf=1", count_s, overflow_s); end
        checks++; if (count_l !== 4'd8 || overflow_l !== 1'b1) begin failures++; $display("FAIL ovf_la count=%0d ovf=%b exp count=8 ovf=1", count_l, overflow_l); end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (overflow_s !== 1'b1 || overflow_l !== 1'b1) begin failures++; $display("FAIL ovf_sticky std=%b la=%b exp 1 1", overflow_s, overflow_l); end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            checks++; if (dout_s !== fill_data[i]) begin failures++; $display("FAIL ovf_drain_std[%0d] got=%h exp=%h", i, dout_s, fill_data[i]); end
        end
        checks++; if (empty_s !== 1'b1 || empty_l !== 1'b1 || underflow_s !== 1'b0) begin failures++; $display("FAIL ovf_drain_end empty_s=%b empty_l=%b udf=%b exp 1 1 0", empty_s, empty_l, underflow_s); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (underflow_s !== 1'b1 || underflow_l !== 1'b1) begin failures++; $display("FAIL udf_set std=%b la=%b exp 1 1", underflow_s, underflow_l); end
        checks++; if (dout_s !== 32'h7A || count_s !== 4'd0) begin failures++; $display("FAIL udf_dout_std dout=%h count=%0d exp dout=7a count=0", dout_s, count_s); end
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        checks++; if ({overflow_s, underflow_s, overflow_l, underflow_l} !== 4'b1111) begin failures++; $display("FAIL flush_keeps_err got=%b exp=1111", {overflow_s, underflow_s, overflow_l, underflow_l}); end
        apply_reset();
        checks++; if ({overflow_s, underflow_s, overflow_l, underflow_l} !== 4'b0000) begin failures++; $display("FAIL rst_clears_err got=%b exp=0000", {overflow_s, underflow_s, overflow_l, underflow_l}); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_std, exp_la;
        apply_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        // Item m of the stream is 0x100+m for m<4, then 0x200+(m-4).
        for (int j = 0; j < 20; j++) begin
            tick(1'b1, 32'h200 + 32'(j), 1'b1, 1'b0);
            exp_std = (j < 4) ? 32'h100 + 32'(j) : 32'h200 + 32'(j - 4);
            exp_la  = (j + 1 < 4) ? 32'h100 + 32'(j + 1) : 32'h200 + 32'(j - 3);
            checks++; if (count_s !== 4'd4 || dout_s !== exp_std) begin failures++; $display("FAIL b2b_std[%0d] count=%0d dout=%h exp count=4 dout=%h", j, count_s, dout_s, exp_std); end
            checks++; if (count_l !== 4'd4 || dout_l !== exp_la || empty_l !== 1'b0) begin failures++; $display("FAIL b2b_la[%0d] count=%0d dout=%h empty=%b exp count=4 dout=%h empty=0", j, count_l, dout_l, empty_l, exp_la); end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
        checks++; if (full_s !== 1'b1 || full_l !== 1'b1) begin failures++; $display("FAIL b2b_full std=%b la=%b exp 1 1", full_s, full_l); end
        tick(1'b1, 32'h3FF, 1'b1, 1'b0);
        checks++; if (count_s !== 4'd7 || overflow_s !== 1'b1 || dout_s !== 32'h210) begin failures++; $display("FAIL full_rdwr_std count=%0d ovf=%b dout=%h exp count=7 ovf=1 dout=210", count_s, overflow_s, dout_s); end
        checks++; if (count_l !== 4'd7 || overflow_l !== 1'b1) begin failures++; $display("FAIL full_rdwr_la count=%0d ovf=%b exp count=7 ovf=1", count_l, overflow_l); end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int i = 0; i < 6; i++) tick(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (count_s !== 4'd5 || count_l !== 4'd5 || dout_s !== 32'h40) begin failures++; $display("FAIL pre_flush count_s=%0d count_l=%0d dout=%h exp 5 5 40", count_s, count_l, dout_s); end
        tick(1'b1, 32'h99, 1'b0, 1'b1);
        checks++; if (count_s !== 4'd0 || empty_s !== 1'b1 || overflow_s !== 1'b0) begin failures++; $display("FAIL flush_std count=%0d empty=%b ovf=%b exp 0 1 0", count_s, empty_s, overflow_s); end
        checks++; if (count_l !== 4'd0 || empty_l !== 1'b1 || overflow_l !== 1'b0) begin failures++; $display("FAIL flush_la count=%0d empty=%b ovf=%b exp 0 1 0", count_l, empty_l, overflow_l); end
        checks++; if (dout_s !== 32'h40) begin failures++; $display("FAIL flush_dout_std got=%h exp=%h", dout_s, 32'h40); end
        tick(1'b1, 32'h11, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (dout_l !== 32'h11 || empty_l !== 1'b0) begin failures++; $display("FAIL post_flush_la dout=%h empty=%b exp 11 0", dout_l, empty_l); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (dout_s !== 32'h11 || count_s !== 4'd0 || count_l !== 4'd0) begin failures++; $display("FAIL post_flush_std dout=%h count_s=%0d count_l=%0d exp 11 0 0", dout_s, count_s, count_l); end
    endtask

    // Scoreboard run: random wr/rd against an expected queue per mode.
    // Lookahead entries carry the edge they were written on; the head is
    // visible once at least one further edge has passed.
    task automatic test_random();
        logic [31:0] exp_s [$];
        logic [31:0] exp_l [$];
        int          tag_l [$];
        logic [31:0] dout_exp_s;
        logic        w, r, vis_l, wa_s, ra_s, wa_l, ra_l;
        logic [31:0] d;
        int          edge_n, written, cycles;
        apply_reset();
        dout_exp_s = 32'h0;
        edge_n = 0; written = 0; cycles = 0;
        while (written < 1000 && cycles < 20000) begin
            w = ($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            vis_l = (exp_l.size() > 0) && (tag_l[0] < edge_n);
            wa_s = w && (exp_s.size() < 8);
            ra_s = r && (exp_s.size() > 0);
            wa_l = w && (exp_l.size() < 8);
            ra_l = r && vis_l;
            if (ra_s) dout_exp_s = exp_s.pop_front();
            if (wa_s) begin exp_s.push_back(d); written++; end
            if (ra_l) begin void'(exp_l.pop_front()); void'(tag_l.pop_front()); end
            if (wa_l) begin exp_l.push_back(d); tag_l.push_back(edge_n + 1); end
            edge_n++;
            cycles++;
            tick(w, d, r, 1'b0);
            vis_l = (exp_l.size() > 0) && (tag_l[0] < edge_n);
            checks++; if (count_s !== 4'(exp_s.size()) || dout_s !== dout_exp_s) begin failures++; $display("FAIL rand_std[%0d] count=%0d dout=%h exp count=%0d dout=%h", cycles, count_s, dout_s, exp_s.size(), dout_exp_s); end
            checks++; if (almost_full_s !== (exp_s.size() >= 7) || almost_empty_s !== (exp_s.size() <= 1) || empty_s !== (exp_s.size() == 0) || full_s !== (exp_s.size() == 8)) begin failures++; $display("FAIL rand_flags_std[%0d] af=%b ae=%b e=%b f=%b size=%0d", cycles, almost_full_s, almost_empty_s, empty_s, full_s, exp_s.size()); end
            checks++; if (count_l !== 4'(exp_l.size()) || empty_l !== !vis_l) begin failures++; $display("FAIL rand_la[%0d] count=%0d empty=%b exp count=%0d empty=%b", cycles, count_l, empty_l, exp_l.size(), !vis_l); end
            checks++; if (almost_full_l !== (exp_l.size() >= 7) || almost_empty_l !== (exp_l.size() <= 1) || full_l !== (exp_l.size() == 8)) begin failures++; $display("FAIL rand_flags_la[%0d] af=%b ae=%b f=%b size=%0d", cycles, almost_full_l, almost_empty_l, full_l, exp_l.size()); end
            if (vis_l) begin
                checks++; if (dout_l !== exp_l[0]) begin failures++; $display("FAIL rand_dout_la[%0d] got=%h exp=%h", cycles, dout_l, exp_l[0]); end
            end
        end
        checks++; if (written < 1000) begin failures++; $display("FAIL rand_budget written=%0d exp=1000", written); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        fill_data[0] = 32'h5A; fill_data[1] = 32'hF6; fill_data[2] = 32'h09; fill_data[3] = 32'hC4;
        fill_data[4] = 32'h81; fill_data[5] = 32'hE2; fill_data[6] = 32'hA0; fill_data[7] = 32'h7A;
        rst = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = 32'h0;
        test_reset();
        test_fill_drain();
        test_lookahead();
        test_overflow_underflow();
        test_back_to_back();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
